// File: rtl/serial_pkg.sv
// Shared types and constants for the serial lane arbiter and the packer it feeds.
package serial_pkg;

   localparam int unsigned SER_MAXLEN     = 64;
   localparam int unsigned SER_FIFO_DEPTH = 32;
   localparam int unsigned SER_LEN_W      = 7;
   localparam int unsigned SER_IDLE_W     = 5;
   localparam int unsigned SER_CRED_W     = 6;
   localparam int unsigned SER_TIMEOUT    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2,
      PAD   = 2'd3
   } arb_state_t;

   // One bit on the packer's serial input bus
   typedef struct packed {
      logic push;
      logic last;
      logic data;
   } ser_bit_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr, else lowest overall.
module rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             win_valid_c,
   output logic [N-1:0]     win_onehot_c,
   output logic [IDX_W-1:0] win_idx_c
);

   logic             hi_v;
   logic [IDX_W-1:0] hi_idx;
   logic [IDX_W-1:0] lo_idx;

   // Scan downward so the last hit is the lowest index in each class
   always_comb begin
      hi_v   = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_idx = IDX_W'(i);
            if (i >= int'(ptr)) begin
               hi_v   = 1'b1;
               hi_idx = IDX_W'(i);
            end
         end
      end
   end

   assign win_valid_c  = |req;
   assign win_idx_c    = hi_v ? hi_idx : lo_idx;
   assign win_onehot_c = win_valid_c ? (N'(1) << win_idx_c) : '0;

endmodule

// File: rtl/serial_lane_arbiter.sv
// Frame-granular round-robin arbiter feeding one serial packer, with credit tracking
// and forced closing of over-long or stalled frames.
module serial_lane_arbiter
   import serial_pkg::*;
#(
   parameter int unsigned N_LANES = 4,
   parameter int unsigned DEPTH   = SER_FIFO_DEPTH,
   parameter int unsigned MAXLEN  = SER_MAXLEN,
   parameter int unsigned TIMEOUT = SER_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_LANES-1:0]    req,
   output logic [N_LANES-1:0]    gnt,
   input  logic [N_LANES-1:0]    lane_push,
   input  logic [N_LANES-1:0]    lane_last,
   input  logic [N_LANES-1:0]    lane_data,
   output logic                  ser_pushin,
   output logic                  ser_lastin,
   output logic                  ser_datain,
   input  logic                  pullout,
   input  logic                  stopout,
   output logic [SER_CRED_W-1:0] credits,
   output logic                  err_trunc,
   output logic                  err_timeout,
   output logic                  err_stray
);

   localparam int unsigned IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

   arb_state_t            state_q, state_d;
   logic [N_LANES-1:0]    gnt_q, gnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [SER_LEN_W-1:0]  len_q, len_d;
   logic [SER_IDLE_W-1:0] idle_q, idle_d;
   logic [SER_CRED_W-1:0] cred_q, cred_d;
   ser_bit_t              ser_q, ser_d;
   logic                  err_trunc_q, err_trunc_d;
   logic                  err_timeout_q, err_timeout_d;
   logic                  err_stray_q, err_stray_d;

   logic                  win_valid_c;
   logic [N_LANES-1:0]    win_onehot_c;
   logic [IDX_W-1:0]      win_idx_c;
   logic                  cr_inc_c;
   logic                  cr_dec_c;

   rr_arbiter #(
      .N     (N_LANES),
      .IDX_W (IDX_W)
   ) u_rr (
      .req          (req),
      .ptr          (rr_ptr_q),
      .win_valid_c  (win_valid_c),
      .win_onehot_c (win_onehot_c),
      .win_idx_c    (win_idx_c)
   );

   // Credit moves on the edge that puts a closing bit onto the packer
   assign cr_inc_c = ser_d.push & ser_d.last;
   assign cr_dec_c = pullout & ~stopout & (cred_q != '0);

   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      idx_d         = idx_q;
      rr_ptr_d      = rr_ptr_q;
      len_d         = len_q;
      idle_d        = idle_q;
      ser_d         = '0;
      err_trunc_d   = 1'b0;
      err_timeout_d = 1'b0;
      err_stray_d   = |(lane_push & ~gnt_q);
      cred_d        = cred_q;

      case (state_q)
         IDLE: begin
            if (win_valid_c && (cred_q < SER_CRED_W'(DEPTH))) begin
               state_d  = GRANT;
               gnt_d    = win_onehot_c;
               idx_d    = win_idx_c;
               rr_ptr_d = (win_idx_c == IDX_W'(N_LANES - 1)) ? '0 : win_idx_c + IDX_W'(1);
               len_d    = '0;
               idle_d   = '0;
            end
         end
         GRANT: begin
            if (lane_push[idx_q]) begin
               ser_d.push = 1'b1;
               ser_d.data = lane_data[idx_q];
               len_d      = len_q + SER_LEN_W'(1);
               idle_d     = '0;
               if (lane_last[idx_q]) begin
                  ser_d.last = 1'b1;
                  state_d    = IDLE;
                  gnt_d      = '0;
               end else if (len_q + SER_LEN_W'(1) == SER_LEN_W'(MAXLEN)) begin
                  ser_d.last  = 1'b1;
                  err_trunc_d = 1'b1;
                  state_d     = DRAIN;
               end
            end else begin
               idle_d = idle_q + SER_IDLE_W'(1);
               // Pad bit is registered on the same edge the state enters PAD
               if (idle_q + SER_IDLE_W'(1) == SER_IDLE_W'(TIMEOUT)) begin
                  ser_d         = '{push: 1'b1, last: 1'b1, data: 1'b0};
                  err_timeout_d = 1'b1;
                  state_d       = PAD;
               end
            end
         end
         DRAIN: begin
            if (lane_push[idx_q] && lane_last[idx_q]) begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         PAD: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase

      if (cr_inc_c && !cr_dec_c && (cred_q != SER_CRED_W'(DEPTH))) begin
         cred_d = cred_q + SER_CRED_W'(1);
      end else if (!cr_inc_c && cr_dec_c) begin
         cred_d = cred_q - SER_CRED_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         gnt_q         <= '0;
         idx_q         <= '0;
         rr_ptr_q      <= '0;
         len_q         <= '0;
         idle_q        <= '0;
         cred_q        <= '0;
         ser_q         <= '0;
         err_trunc_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         err_stray_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         idx_q         <= idx_d;
         rr_ptr_q      <= rr_ptr_d;
         len_q         <= len_d;
         idle_q        <= idle_d;
         cred_q        <= cred_d;
         ser_q         <= ser_d;
         err_trunc_q   <= err_trunc_d;
         err_timeout_q <= err_timeout_d;
         err_stray_q   <= err_stray_d;
      end
   end

   assign gnt         = gnt_q;
   assign ser_pushin  = ser_q.push;
   assign ser_lastin  = ser_q.last;
   assign ser_datain  = ser_q.data;
   assign credits     = cred_q;
   assign err_trunc   = err_trunc_q;
   assign err_timeout = err_timeout_q;
   assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Directed bench for serial_lane_arbiter: a vector table plus hand sequences for
// round-robin order, truncation, timeout padding and credit back-pressure.
module tb_serial_lane_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req, gnt, lane_push, lane_last, lane_data;
   logic       ser_pushin, ser_lastin, ser_datain;
   logic       pullout, stopout;
   logic [5:0] credits;
   logic       err_trunc, err_timeout, err_stray;

   int n_tests = 0;
   int n_fail  = 0;

   serial_lane_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .gnt         (gnt),
      .lane_push   (lane_push),
      .lane_last   (lane_last),
      .lane_data   (lane_data),
      .ser_pushin  (ser_pushin),
      .ser_lastin  (ser_lastin),
      .ser_datain  (ser_datain),
      .pullout     (pullout),
      .stopout     (stopout),
      .credits     (credits),
      .err_trunc   (err_trunc),
      .err_timeout (err_timeout),
      .err_stray   (err_stray)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req, push, last, data;
      logic       pull, stop;
      logic [3:0] gnt;
      logic       sp, sl, sd;
      logic [5:0] cred;
      logic       et, eto, es;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] ps, input logic [3:0] ls,
                               input logic [3:0] dt, input logic pl, input logic st,
                               input logic [3:0] g, input logic sp, input logic sl, input logic sd,
                               input logic [5:0] cr, input logic et, input logic eto, input logic es);
      vec_t v;
      v.req = rq; v.push = ps; v.last = ls; v.data = dt; v.pull = pl; v.stop = st;
      v.gnt = g; v.sp = sp; v.sl = sl; v.sd = sd; v.cred = cr; v.et = et; v.eto = eto; v.es = es;
      return v;
   endfunction

   function automatic logic [15:0] obs();
      return {gnt, ser_pushin, ser_lastin, ser_datain, credits, err_trunc, err_timeout, err_stray};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      req = '0; lane_push = '0; lane_last = '0; lane_data = '0;
      pullout = 1'b0; stopout = 1'b0;
   endtask

   task automatic do_reset(input string name);
      rst = 1'b0;
      clear_inputs();
      step();
      step();
      chk(name, 32'(obs()), 32'h0);
      rst = 1'b1;
   endtask

   task automatic wait_gnt(input string name, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (gnt != '0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no grant within 20 cycles", name);
      end
   endtask

   vec_t vt[14];

   initial begin : main
      logic ok;
      logic [3:0] mask;
      int pcnt, lastcnt, lastpos, trunc_n, data_errs, stray_n, idle_n;

      //             req    push   last   data   pl st  gnt   sp sl sd cred et to es
      vt[0]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0010, 0, 0, 0, 6'd0, 0, 0, 0);
      vt[1]  = mk(4'b0000, 4'b0010, 4'b0000, 4'b0010, 0, 0, 4'b0010, 1, 0, 1, 6'd0, 0, 0, 0);
      vt[2]  = mk(4'b0000, 4'b0010, 4'b0000, 4'b0000, 0, 0, 4'b0010, 1, 0, 0, 6'd0, 0, 0, 0);
      vt[3]  = mk(4'b0000, 4'b0010, 4'b0000, 4'b0010, 0, 0, 4'b0010, 1, 0, 1, 6'd0, 0, 0, 0);
      vt[4]  = mk(4'b0000, 4'b0010, 4'b0000, 4'b0010, 0, 0, 4'b0010, 1, 0, 1, 6'd0, 0, 0, 0);
      vt[5]  = mk(4'b0000, 4'b0010, 4'b0010, 4'b0000, 0, 0, 4'b0000, 1, 1, 0, 6'd1, 0, 0, 0);
      vt[6]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 6'd1, 0, 0, 0);
      vt[7]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 0, 0, 6'd1, 0, 0, 0);
      vt[8]  = mk(4'b0000, 4'b0101, 4'b0000, 4'b0001, 0, 0, 4'b0001, 1, 0, 1, 6'd1, 0, 0, 1);
      vt[9]  = mk(4'b0000, 4'b0001, 4'b0001, 4'b0000, 1, 0, 4'b0000, 1, 1, 0, 6'd1, 0, 0, 0);
      vt[10] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0, 0, 6'd1, 0, 0, 0);
      vt[11] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 6'd0, 0, 0, 0);
      vt[12] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 6'd0, 0, 0, 0);
      vt[13] = mk(4'b0000, 4'b1000, 4'b0000, 4'b1000, 0, 0, 4'b0000, 0, 0, 0, 6'd0, 0, 0, 1);

      // Vector table: lane-1 frame 10110, then stray push and close-with-pop
      do_reset("reset_state");
      for (int i = 0; i < 14; i++) begin
         req = vt[i].req; lane_push = vt[i].push; lane_last = vt[i].last;
         lane_data = vt[i].data; pullout = vt[i].pull; stopout = vt[i].stop;
         step();
         chk($sformatf("vec[%0d]", i), 32'(obs()),
             32'({vt[i].gnt, vt[i].sp, vt[i].sl, vt[i].sd, vt[i].cred, vt[i].et, vt[i].eto, vt[i].es}));
      end
      clear_inputs();

      // Round-robin order with all lanes requesting continuously
      do_reset("reset_rr");
      req = 4'hF;
      for (int f = 0; f < 5; f++) begin
         mask = 4'(1 << (f % 4));
         wait_gnt("rr_wait", ok);
         chk($sformatf("rr_grant[%0d]", f), 32'(gnt), 32'(mask));
         for (int b = 0; b < 3; b++) begin
            lane_push = mask;
            lane_data = mask;
            lane_last = (b == 2) ? mask : 4'b0000;
            step();
         end
         lane_push = '0; lane_last = '0; lane_data = '0;
      end
      req = '0;
      chk("rr_credits", 32'(credits), 32'd5);
      step();
      chk("rr_idle_gnt", 32'(gnt), 32'd0);

      // Truncation at 64 bits, remaining bits drained until the lane's last
      do_reset("reset_trunc");
      req = 4'b0001;
      wait_gnt("trunc_wait", ok);
      req = '0;
      pcnt = 0; lastcnt = 0; lastpos = 0; trunc_n = 0; data_errs = 0; stray_n = 0;
      for (int b = 1; b <= 70; b++) begin
         lane_push = 4'b0001;
         lane_data = 4'(b % 2);
         lane_last = (b == 70) ? 4'b0001 : 4'b0000;
         step();
         if (ser_pushin) begin
            pcnt++;
            if (ser_datain !== 1'(pcnt % 2)) data_errs++;
            if (ser_lastin) begin
               lastcnt++;
               lastpos = pcnt;
            end
         end
         if (err_trunc) trunc_n++;
         if (err_stray) stray_n++;
      end
      lane_push = '0; lane_last = '0; lane_data = '0;
      chk("trunc_bits_out", 32'(pcnt), 32'd64);
      chk("trunc_last_count", 32'(lastcnt), 32'd1);
      chk("trunc_last_pos", 32'(lastpos), 32'd64);
      chk("trunc_err_pulses", 32'(trunc_n), 32'd1);
      chk("trunc_data_errs", 32'(data_errs), 32'd0);
      chk("trunc_no_stray", 32'(stray_n), 32'd0);
      chk("trunc_gnt_low", 32'(gnt), 32'd0);
      chk("trunc_credits", 32'(credits), 32'd1);

      // Stalled lane 1 after 3 bits: pad bit after 16 idle cycles
      req = 4'b0010;
      wait_gnt("to_wait", ok);
      chk("to_grant", 32'(gnt), 32'b0010);
      req = '0;
      for (int b = 0; b < 3; b++) begin
         lane_push = 4'b0010;
         lane_data = 4'b0010;
         step();
      end
      lane_push = '0; lane_data = '0;
      idle_n = 0;
      while (idle_n < 40) begin
         step();
         idle_n++;
         if (ser_pushin) break;
      end
      chk("to_idle_cycles", 32'(idle_n), 32'd16);
      chk("to_pad_bit", 32'({ser_pushin, ser_lastin, ser_datain, err_timeout}), 32'b1101);
      chk("to_credits", 32'(credits), 32'd2);
      step();
      chk("to_after_pad", 32'({gnt, ser_pushin, err_timeout}), 32'd0);

      // Credit back-pressure: 32 frames fill the packer, one pop re-opens it
      do_reset("reset_full");
      req = 4'b0001;
      for (int f = 0; f < 32; f++) begin
         wait_gnt("full_wait", ok);
         if (!ok) break;
         lane_push = 4'b0001; lane_last = 4'b0001;
         step();
         lane_push = '0; lane_last = '0;
      end
      chk("full_credits", 32'(credits), 32'd32);
      mask = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         mask = mask | gnt;
      end
      chk("full_no_grant", 32'(mask), 32'd0);
      pullout = 1'b1; stopout = 1'b0;
      step();
      pullout = 1'b0;
      chk("full_pop", 32'({gnt, credits}), 32'({4'b0000, 6'd31}));
      step();
      chk("full_regrant", 32'(gnt), 32'b0001);
      req = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/serial_lane_arbiter.md
# serial_lane_arbiter

Round-robin frame arbiter that shares the single `serial` SIPO packer among `N_LANES` serial bit-stream sources. It grants one lane at a time for a whole frame and forwards that lane's push/last/data bits, registered, onto the packer's serial inputs. It tracks packer FIFO occupancy with a frame credit counter, so it never overflows the packer. It closes runaway or stalled frames so the packer always receives well-formed frames of 1–64 bits.

## Interface
- `N_LANES`, 4, number of requesting serial sources (2–8)
- `DEPTH`, 32, packer FIFO depth in frames; credit limit
- `MAXLEN`, 64, maximum frame length in bits
- `TIMEOUT`, 16, idle cycles a granted lane may go without pushing before its frame is force-closed
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-low reset
- `req` in N_LANES: lane requests a frame slot; held until its `gnt` bit rises
- `gnt` out N_LANES: one-hot grant, registered
- `lane_push` in N_LANES: lane bit valid
- `lane_last` in N_LANES: lane's final bit of frame (qualified by `lane_push`)
- `lane_data` in N_LANES: lane serial data bit
- `ser_pushin` out 1: to packer `pushin`
- `ser_lastin` out 1: to packer `lastin`
- `ser_datain` out 1: to packer `datain`
- `pullout` in 1: packer consumer pull, observed only
- `stopout` in 1: packer output-not-valid, observed only
- `credits` out 6: frames currently held in packer FIFO, 0..DEPTH
- `err_trunc` out 1: one-cycle pulse, frame truncated at MAXLEN
- `err_timeout` out 1: one-cycle pulse, frame closed by timeout
- `err_stray` out 1: one-cycle pulse, push from an ungranted lane was dropped

## Operation
- States: IDLE, GRANT, DRAIN, PAD.
- IDLE: if any `req` and `credits < DEPTH`, the round-robin winner is chosen. Search starts at `rr_ptr`. Next cycle `gnt[w]=1`, state becomes GRANT, `rr_ptr = w+1` mod N_LANES. If no request or `credits == DEPTH`, stay in IDLE.
- GRANT: each `lane_push[w]` is forwarded as `ser_pushin=1` with `ser_datain=lane_data[w]` and `ser_lastin=lane_last[w]`.
  - A 7-bit length counter increments per bit.
  - A 5-bit idle counter clears on each push.
  - On `lane_last[w]`: state becomes IDLE and `gnt` goes to 0.
  - On the MAXLEN-th bit without last: `ser_lastin` is forced to 1, `err_trunc` pulses, and state becomes DRAIN.
  - If the idle counter reaches TIMEOUT: state becomes PAD.
- DRAIN: `gnt[w]` stays 1. The lane's further bits are discarded. On `lane_last[w]`, state becomes IDLE.
- PAD: emits one cycle of `ser_pushin=1`, `ser_lastin=1`, `ser_datain=0`, and pulses `err_timeout`. Then state becomes IDLE and `gnt` goes to 0.
- Any `lane_push` from a lane whose `gnt` is 0 is dropped and pulses `err_stray`.
- Credit counter:
  - Increments when `ser_lastin & ser_pushin` is driven.
  - Decrements when `pullout & ~stopout`.
  - Simultaneous increment and decrement leave it unchanged.
  - It never exceeds DEPTH and never underflows; a decrement at 0 is ignored.
- Reset values: `gnt=0`, `ser_*=0`, `credits=0`, all err pulses 0, state IDLE, `rr_ptr=0`, counters 0.
- Reset mid-frame abandons the frame; the packer is reset with the same reset domain.

## Timing
- `req` seen in IDLE at cycle t → `gnt` is high in cycle t+1.
- Lane bit sampled at edge e → `ser_*` valid in the cycle after e (1-cycle latency).
- `lane_last` sampled at edge e → `gnt` is low after e.
- IDLE lasts at least one cycle between frames, so back-to-back grants are 1 cycle apart.
- Credit check uses the registered `credits` value.
- Timeout: TIMEOUT consecutive granted cycles with no `lane_push[w]` → the PAD bit appears on the next cycle.
- Err pulses are registered and coincide with the `ser_*` cycle they describe. `err_stray` pulses the cycle after the stray push.

## Structure
- Package `serial_pkg` holds:
  - state enum `arb_state_t` (IDLE, GRANT, DRAIN, PAD)
  - constants `SER_MAXLEN=64`, `SER_FIFO_DEPTH=32`, `SER_LEN_W=7`
- Sub-module `rr_arbiter`: combinational N-way round-robin pick from `req` and `rr_ptr`, producing a one-hot winner and its index.
- FSM, counters and output registers live in `serial_lane_arbiter`.

## Test plan
- Lane 1 requests, sends a 5-bit frame `10110` with last on bit 5 → `ser_datain` shows `10110` one cycle delayed, `ser_lastin` on the 5th bit, `credits=1`, `gnt` drops.
- All 4 lanes request continuously, each sending 3-bit frames → grants in order 0,1,2,3,0; no lane is granted twice in a row.
- Lane 0 sends 70 bits with no last → `ser_lastin` on bit 64, `err_trunc` pulses once, bits 65–70 dropped, return to IDLE on lane's last.
- Granted lane stops pushing after 3 bits → after 16 idle cycles, one PAD bit (`datain=0`, `lastin=1`), `err_timeout`, `credits` incremented.
- Fill 32 frames with `pullout=0` → `credits=32`, new `req` is not granted. One pop (`pullout=1`, `stopout=0`) gives `credits=31` and the grant follows.
- Lane 2 pushes while lane 0 is granted → `err_stray` pulses; lane 0's stream is unaffected. Frame close and pop in the same cycle leave `credits` unchanged.
